// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction-fetch controller. Drives the external PC register (enable,
// load, load address), runs a single-outstanding request/response exchange
// with instruction memory, and presents each fetched instruction with its
// address to decode over a valid/ready handshake. Branch redirects reload
// the PC and cancel any in-flight or held fetch.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   pc                         current PC register value
//   pc_en, pc_load             PC update strobe; load when pc_load else +1
//   pc_load_addr               load value (the redirect target)
//   imem_req_valid/ready/addr  fetch request channel
//   imem_rsp_valid/data        one-cycle response strobe and instruction word
//   inst_valid/ready           decode handshake
//   inst_data, inst_pc         held instruction and its address
//   redirect_valid/addr        taken branch/jump from execute
//   halt                       stop issuing fetches at the next idle point
//   busy                       sequencer not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fetch in progress; leaves when halt is low
// REQ   | request presented to memory at the current pc
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction held for decode (inst_valid high)
// DRAIN | waiting to swallow the response of a cancelled request

module fetch_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              req_vld_q;
    logic [ADDR_W-1:0] req_pc;
    logic              req_fire;
    logic              rsp_take;

    // Request valid is registered so that a redirect seen in REQ (without a
    // handshake) suppresses it for exactly the following cycle, giving the
    // PC register one clean cycle to present the new target.
    assign imem_req_valid = req_vld_q;
    assign imem_req_addr  = pc;
    assign req_fire       = req_vld_q && imem_req_ready;

    // A response that coincides with a redirect is discarded.
    assign rsp_take = (state == WAIT) && imem_rsp_valid && !redirect_valid;

    assign pc_en        = redirect_valid || rsp_take;
    assign pc_load      = redirect_valid;
    assign pc_load_addr = redirect_addr;

    assign inst_valid = (state == HOLD);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            case (state)
                IDLE:    state_nxt = halt ? IDLE : REQ;
                REQ:     state_nxt = req_fire ? DRAIN : REQ;
                WAIT:    state_nxt = imem_rsp_valid ? REQ : DRAIN;
                HOLD:    state_nxt = REQ;
                DRAIN:   state_nxt = imem_rsp_valid ? REQ : DRAIN;
                default: state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE:    if (!halt) state_nxt = REQ;
                REQ:     if (req_fire) state_nxt = WAIT;
                WAIT:    if (imem_rsp_valid) state_nxt = HOLD;
                HOLD:    if (inst_ready) state_nxt = halt ? IDLE : REQ;
                DRAIN:   if (imem_rsp_valid) state_nxt = halt ? IDLE : REQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_vld_q <= 1'b0;
            req_pc    <= '0;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            state     <= state_nxt;
            req_vld_q <= (state_nxt == REQ) && !((state == REQ) && redirect_valid);
            if (req_fire) begin
                req_pc <= pc;
            end
            if (rsp_take) begin
                inst_data <= imem_rsp_data;
                inst_pc   <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en, pc_load;
    logic [31:0] pc_load_addr;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt, busy;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .pc_en(pc_en), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .halt(halt), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // memory model: single pending request answered lat_cur cycles later
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          lat_cur = 1;

    typedef struct {
        bit          rr, ird, hlt, rdv;
        logic [31:0] raddr;
        int          lat;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_ipc;
        bit          e_en, e_ld, e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rr, bit ird, bit hlt, bit rdv, logic [31:0] raddr,
                                int lat, bit e_req, logic [31:0] e_addr, bit e_iv,
                                logic [31:0] e_ipc, bit e_en, bit e_ld, bit e_busy);
        vec_t v;
        v.rr = rr; v.ird = ird; v.hlt = hlt; v.rdv = rdv; v.raddr = raddr; v.lat = lat;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
        v.e_en = e_en; v.e_ld = e_ld; v.e_busy = e_busy;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Capture handshake / PC update seen this cycle, advance to the next cycle,
    // then drive the PC register and memory response for that cycle.
    task automatic env_edge();
        logic [31:0] pc_nxt;
        if (!rst_n) begin
            pend = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            pend      = 1;
            pend_addr = imem_req_addr;
            pend_cnt  = lat_cur;
        end
        pc_nxt = pc;
        if (pc_en) pc_nxt = pc_load ? pc_load_addr : pc + 32'd1;
        @(posedge clk);
        #1;
        pc = pc_nxt;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_addr + 32'h100;
                pend = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          delivered;
        bit          found;
        bit          p_iv, p_ird, p_rdv, p_req, p_rr;
        logic [31:0] p_ipc, p_idata, p_addr;

        rst_n = 1'b0; pc = 32'd0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; inst_ready = 1'b1; redirect_valid = 1'b0;
        redirect_addr = '0; halt = 1'b1;

        // ---------------- directed table ----------------
        add(1,1,1,0,0,1, 0,0, 0,0, 0,0,0);
        add(1,1,0,0,0,1, 0,0, 0,0, 0,0,0);
        for (int k = 0; k < 4; k++) begin
            add(1,1,0,0,0,1, 1,k, 0,0, 0,0,1);
            add(1,1,0,0,0,1, 0,0, 0,0, 1,0,1);
            add(1,1,0,0,0,1, 0,0, 1,k, 0,0,1);
        end
        for (int k = 0; k < 4; k++) add(0,1,0,0,0,1, 1,4, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 1,4, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 0,0, 0,0, 1,0,1);
        for (int k = 0; k < 5; k++) add(1,0,0,0,0,1, 0,0, 1,4, 0,0,1);
        add(1,1,0,0,0,1, 0,0, 1,4, 0,0,1);
        add(1,1,0,0,0,3, 1,5, 0,0, 0,0,1);
        add(1,1,0,1,32'h40,1, 0,0, 0,0, 1,1,1);
        add(1,1,0,0,0,1, 0,0, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 0,0, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 1,32'h40, 0,0, 0,0,1);
        add(1,1,0,1,32'h80,1, 0,0, 0,0, 1,1,1);
        add(1,1,0,0,0,1, 1,32'h80, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 0,0, 0,0, 1,0,1);
        add(1,1,0,1,32'h20,1, 0,0, 1,32'h80, 1,1,1);
        add(0,1,0,1,32'h30,1, 1,32'h20, 0,0, 1,1,1);
        add(1,1,0,0,0,1, 0,0, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 1,32'h30, 0,0, 0,0,1);
        add(1,1,0,0,0,1, 0,0, 0,0, 1,0,1);
        add(1,0,1,0,0,1, 0,0, 1,32'h30, 0,0,1);
        add(1,1,1,0,0,1, 0,0, 1,32'h30, 0,0,1);
        add(1,1,1,0,0,1, 0,0, 0,0, 0,0,0);
        add(1,1,1,0,0,1, 0,0, 0,0, 0,0,0);
        add(1,1,0,0,0,1, 0,0, 0,0, 0,0,0);
        add(1,1,0,0,0,2, 1,32'h31, 0,0, 0,0,1);

        @(negedge clk);
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_inst_valid", inst_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_inst_data", inst_data, 0);
        chk("reset_inst_pc", inst_pc, 0);
        chk("reset_pc_en", pc_en, 0);
        env_edge();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            imem_req_ready = vecs[i].rr;
            inst_ready     = vecs[i].ird;
            halt           = vecs[i].hlt;
            redirect_valid = vecs[i].rdv;
            redirect_addr  = vecs[i].raddr;
            lat_cur        = vecs[i].lat;
            @(negedge clk);
            chk($sformatf("row%0d_req_valid", i), imem_req_valid, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("row%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            chk($sformatf("row%0d_inst_valid", i), inst_valid, vecs[i].e_iv);
            if (vecs[i].e_iv) begin
                chk($sformatf("row%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
                chk($sformatf("row%0d_inst_data", i), inst_data, vecs[i].e_ipc + 32'h100);
            end
            chk($sformatf("row%0d_pc_en", i), pc_en, vecs[i].e_en);
            chk($sformatf("row%0d_pc_load", i), pc_load, vecs[i].e_ld);
            if (vecs[i].e_ld) chk($sformatf("row%0d_pc_load_addr", i), pc_load_addr, vecs[i].raddr);
            chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
            env_edge();
        end

        // ---------------- reset while waiting for a response ----------------
        redirect_valid = 1'b0; halt = 1'b0; inst_ready = 1'b1;
        imem_req_ready = 1'b1; lat_cur = 1;
        rst_n = 1'b0; pend = 0; imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("midwait_rst_busy", busy, 0);
        chk("midwait_rst_req_valid", imem_req_valid, 0);
        chk("midwait_rst_inst_data", inst_data, 0);
        chk("midwait_rst_inst_pc", inst_pc, 0);
        env_edge();
        rst_n = 1'b1;
        found = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (inst_valid) begin
                found = 1;
                chk("resume_inst_pc", inst_pc, 32'h31);
                chk("resume_inst_data", inst_data, 32'h131);
            end
            env_edge();
        end
        chk("resume_seen", found, 1);

        // ---------------- randomized run against scoreboard ----------------
        rst_n = 1'b0; pend = 0; imem_rsp_valid = 1'b0; halt = 1'b0;
        pc = $urandom;
        exp_pc = pc;
        @(negedge clk);
        env_edge();
        rst_n = 1'b1;
        delivered = 0;
        p_iv = 0; p_ird = 0; p_rdv = 0; p_req = 0; p_rr = 0;
        p_ipc = '0; p_idata = '0; p_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            imem_req_ready = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            lat_cur        = $urandom_range(1, 3);
            redirect_valid = !p_rdv && (($urandom % 16) == 0);
            redirect_addr  = $urandom;
            if (($urandom % 64) == 0) halt = !halt;
            @(negedge clk);
            if (pc_load) begin
                chk("load_implies_en", pc_en, 1);
                chk("load_addr", pc_load_addr, redirect_addr);
            end
            if (pc_en && !pc_load) chk("incr_only_on_rsp", imem_rsp_valid, 1);
            if (imem_req_valid) begin
                chk("req_addr_is_pc", imem_req_addr, pc);
                chk("single_outstanding", pend || imem_rsp_valid, 0);
            end
            if (!busy) chk("idle_quiet", imem_req_valid || inst_valid, 0);
            if (p_req && !p_rr && !p_rdv) begin
                chk("req_hold_valid", imem_req_valid, 1);
                chk("req_hold_addr", imem_req_addr, p_addr);
            end
            if (p_iv && !p_ird && !p_rdv) begin
                chk("inst_hold_valid", inst_valid, 1);
                chk("inst_hold_pc", inst_pc, p_ipc);
                chk("inst_hold_data", inst_data, p_idata);
            end
            if (p_iv && p_rdv) chk("redirect_drops_inst", inst_valid, 0);
            if (inst_valid && inst_ready && !redirect_valid) begin
                chk("deliver_pc", inst_pc, exp_pc);
                chk("deliver_data", inst_data, exp_pc + 32'h100);
                exp_pc = exp_pc + 32'd1;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_addr;
            p_iv = inst_valid; p_ird = inst_ready; p_rdv = redirect_valid;
            p_ipc = inst_pc; p_idata = inst_data;
            p_req = imem_req_valid; p_rr = imem_req_ready; p_addr = imem_req_addr;
            env_edge();
        end
        chk("random_progress", delivered > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the RISC core. It sequences the program counter register by driving its enable, load and load-address inputs. It runs a single-outstanding request/response exchange with instruction memory and presents each fetched instruction, tagged with its address, to decode over a valid/ready handshake. Branch redirects from execute reload the PC and cancel in-flight or held fetches.

## Interface
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  current value of the program counter register
- pc_en  out  1  PC update strobe (combinational)
- pc_load  out  1  with pc_en: load pc_load_addr; otherwise increment by 1 (combinational)
- pc_load_addr  out  ADDR_W  equals redirect_addr (combinational)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  equals pc while imem_req_valid
- imem_rsp_valid  in  1  one-cycle response strobe, exactly one per accepted request, earliest one cycle after acceptance
- imem_rsp_data  in  DATA_W  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst_data  out  DATA_W  held instruction
- inst_pc  out  ADDR_W  address of held instruction
- redirect_valid  in  1  branch/jump taken, single-cycle
- redirect_addr  in  ADDR_W  redirect target
- halt  in  1  stop issuing new fetches at the next idle point
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Reset state IDLE.
- IDLE: go to REQ when !halt.
- REQ: imem_req_valid=1. On handshake, capture pc into the req_pc register and go to WAIT. Once asserted, imem_req_valid holds until handshake or redirect. halt is not sampled here.
- WAIT: on imem_rsp_valid, latch imem_rsp_data into inst_data and req_pc into inst_pc, assert pc_en=1 / pc_load=0 that cycle (PC increments at that edge), and go to HOLD.
- HOLD: inst_valid=1. On inst_ready, go to IDLE if halt, else go to REQ.
- DRAIN: wait for the response of a cancelled request, discard it, then go to IDLE if halt, else go to REQ.
- Redirect (redirect_valid=1) has priority over everything. It asserts pc_en=1 and pc_load=1 in the same cycle, and the next state is:
  - IDLE: stays IDLE if halt, else REQ.
  - REQ without handshake: REQ. imem_req_valid drops for one cycle, then reasserts with the new pc.
  - REQ with handshake in the same cycle: DRAIN.
  - WAIT without rsp: DRAIN.
  - WAIT with rsp in the same cycle: response discarded, PC not incremented, go to REQ.
  - HOLD: instruction dropped (inst_valid low next cycle even if inst_ready was high), go to REQ.
  - DRAIN: stays DRAIN. A rsp arriving that cycle still completes the drain, and the next state is REQ.
- At most one pc_en pulse per cycle. pc_load is never asserted without pc_en.
- Address arithmetic is performed by the PC register (+1, wraps modulo 2^ADDR_W); the sequencer never computes addresses.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, req_pc=0, busy=0. pc_en and pc_load are 0 unless redirect_valid is high.
- Release of rst_n before edge E: IDLE at E; imem_req_valid=1 from E+1 if halt is low.
- Zero-wait memory (ready=1, rsp one cycle after acceptance): request cycle, response cycle, then inst_valid the next cycle. Issue interval is 3 cycles with inst_ready=1.
- inst_valid, inst_data and inst_pc are registered and stable while inst_valid && !inst_ready.
- Reset asserted mid-WAIT: the pending response is ignored. Memory must also be reset by the same rst_n.

## Test plan
- Reset, pc=0, zero-wait memory returning data=addr+0x100, inst_ready=1: inst_pc 0,1,2,3 carry data 0x100..0x103. Exactly one pc_en (pc_load=0) per instruction, and inst_valid is high every third cycle.
- imem_req_ready low for 4 cycles: imem_req_valid and imem_req_addr hold stable, no pc_en, then fetch completes normally.
- inst_ready low for 5 cycles in HOLD: inst_valid/inst_data/inst_pc held, no new imem request until inst_ready is seen high.
- redirect_valid to 0x40 in WAIT with response 2 cycles later: pc_en=1/pc_load=1/pc_load_addr=0x40 that cycle, the late response is not presented, and the next request address is 0x40.
- redirect in the same cycle as the WAIT response: the response is discarded, no increment, the next request goes to the target. A redirect in HOLD drops the held instruction, with inst_valid low the following cycle.
- halt high while in HOLD: after inst_ready, the state is IDLE, busy=0 and no request is issued. Deasserting halt produces a request at the current pc one cycle later.
